// File: rtl/ram_pkg.sv
// Shared definitions for the synchronous clearable RAM: clear-sequencer state
// encoding, default geometry and the even-parity helper.
package ram_pkg;

    localparam int unsigned DW_DEF    = 4;
    localparam int unsigned AW_DEF    = 2;
    localparam int unsigned PAR_MAX_W = 64;

    typedef enum logic {
        S_CLEAR = 1'b0,
        S_READY = 1'b1
    } clr_state_e;

    // Even parity bit: makes the total count of ones in {par, word} even.
    // Callers zero-extend their word to PAR_MAX_W bits, which leaves the XOR unchanged.
    function automatic logic par_even(input logic [PAR_MAX_W-1:0] word);
        return ^word;
    endfunction

endpackage

// File: rtl/ram_sync_clr_if.sv
// Access bus of ram_sync_clr.
// master: drives en/we/a/d/clr, receives q/qv/rdy (and perr when RAM_PARITY_EN is defined).
// slave : the RAM side.
interface ram_sync_clr_if #(
    parameter int unsigned DW = 4,
    parameter int unsigned AW = 2
) ();
    logic          en;
    logic          we;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic          clr;
    logic [DW-1:0] q;
    logic          qv;
    logic          rdy;
`ifdef RAM_PARITY_EN
    logic          perr;

    modport master (output en, we, a, d, clr, input q, qv, rdy, perr);
    modport slave  (input en, we, a, d, clr, output q, qv, rdy, perr);
`else
    modport master (output en, we, a, d, clr, input q, qv, rdy);
    modport slave  (input en, we, a, d, clr, output q, qv, rdy);
`endif
endinterface

// File: rtl/ram_clr_seq.sv
// Clear sequencer: after reset or a clr pulse, walks every address once,
// requesting an INIT_VAL write each cycle, then reports ready.
//   clk_i      : clock, rising edge
//   rst_i      : asynchronous active-high reset
//   clr_i      : restart the clear walk from address 0
//   clr_we_o   : clear write request (high for the whole walk)
//   clr_addr_o : address being cleared
//   rdy_o      : array initialised, user accesses accepted
module ram_clr_seq
    import ram_pkg::*;
#(
    parameter int unsigned AW = AW_DEF
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          clr_i,
    output logic          clr_we_o,
    output logic [AW-1:0] clr_addr_o,
    output logic          rdy_o
);

    localparam logic [AW-1:0] LAST_ADDR = {AW{1'b1}};

    clr_state_e    state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;

    // State and counter registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_CLEAR;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state; the compare at LAST_ADDR ends the walk before the counter wraps
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_CLEAR: begin
                if (clr_i) begin
                    cnt_d = '0;
                end else if (cnt_q == LAST_ADDR) begin
                    state_d = S_READY;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + AW'(1);
                end
            end
            S_READY: begin
                if (clr_i) begin
                    state_d = S_CLEAR;
                    cnt_d   = '0;
                end
            end
            default: state_d = S_CLEAR;
        endcase
    end

    assign clr_we_o   = (state_q == S_CLEAR);
    assign clr_addr_o = cnt_q;
    assign rdy_o      = (state_q == S_READY);

endmodule

// File: rtl/ram_sync_clr.sv
// Synchronous single-port RAM with 1-cycle registered read, read-valid strobe
// and a hardware clear sequencer that fills the array with INIT_VAL.
// Optional feature macro: RAM_PARITY_EN (per-word even parity, perr output).
//   clk_i : clock, rising edge
//   rst_i : asynchronous active-high reset
//   bus   : ram_sync_clr_if.slave (en, we, a, d, clr in; q, qv, rdy [, perr] out)
module ram_sync_clr
    import ram_pkg::*;
#(
    parameter int unsigned   DW       = DW_DEF,
    parameter int unsigned   AW       = AW_DEF,
    parameter logic [DW-1:0] INIT_VAL = '0
) (
    input  logic              clk_i,
    input  logic              rst_i,
    ram_sync_clr_if.slave     bus
);

    localparam int unsigned DEPTH = 1 << AW;
`ifdef RAM_PARITY_EN
    localparam int unsigned WW = DW + 1;
`else
    localparam int unsigned WW = DW;
`endif

    logic [WW-1:0] mem_q [DEPTH];

    logic          clr_we;
    logic [AW-1:0] clr_addr;
    logic          rdy;

    ram_clr_seq #(.AW(AW)) u_clr_seq (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .clr_i      (bus.clr),
        .clr_we_o   (clr_we),
        .clr_addr_o (clr_addr),
        .rdy_o      (rdy)
    );

    // A clr pulse takes priority: any access in the same cycle is dropped
    logic user_acc, wr_en, rd_en;
    assign user_acc = rdy & bus.en & ~bus.clr;
    assign wr_en    = clr_we | (user_acc & bus.we);
    assign rd_en    = user_acc & ~bus.we;

    // Single write port shared between the clear walk and the user
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic [WW-1:0] wr_word;
    logic [WW-1:0] rd_word;
    assign wr_addr = clr_we ? clr_addr : bus.a;
    assign wr_data = clr_we ? INIT_VAL : bus.d;
`ifdef RAM_PARITY_EN
    assign wr_word = {par_even(PAR_MAX_W'(wr_data)), wr_data};
`else
    assign wr_word = wr_data;
`endif
    assign rd_word = mem_q[bus.a];

    // Storage array; contents are established by the clear walk, not by reset
    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_word;
        end
    end

    logic [DW-1:0] q_q;
    logic          qv_q;
`ifdef RAM_PARITY_EN
    logic          perr_q;

    // Read data, strobe and parity check registered together
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            q_q    <= '0;
            qv_q   <= 1'b0;
            perr_q <= 1'b0;
        end else begin
            qv_q <= rd_en;
            if (rd_en) begin
                q_q    <= rd_word[DW-1:0];
                perr_q <= par_even(PAR_MAX_W'(rd_word[DW-1:0])) != rd_word[DW];
            end
        end
    end

    assign bus.perr = perr_q;
`else
    // Read data and strobe; q holds between reads
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            q_q  <= '0;
            qv_q <= 1'b0;
        end else begin
            qv_q <= rd_en;
            if (rd_en) begin
                q_q <= rd_word[DW-1:0];
            end
        end
    end
`endif

    assign bus.q   = q_q;
    assign bus.qv  = qv_q;
    assign bus.rdy = rdy;

endmodule

// File: tb/tb_ram_sync_clr.sv
// Self-checking bench for ram_sync_clr (DW=4, AW=2, INIT_VAL=0): directed
// scenarios plus random traffic against a behavioural model of the RAM.
module tb_ram_sync_clr;

    localparam int unsigned DW    = 4;
    localparam int unsigned AW    = 2;
    localparam int unsigned DEPTH = 4;

    logic clk_i = 1'b0;
    logic rst_i = 1'b1;

    always #5 clk_i = ~clk_i;

    ram_sync_clr_if #(.DW(DW), .AW(AW)) bus ();

    ram_sync_clr #(.DW(DW), .AW(AW), .INIT_VAL(4'h0)) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Behavioural model: contents, remaining clear cycles, last read data/strobe
    logic [DW-1:0] m_mem [DEPTH];
    int            m_clr_left;
    logic [DW-1:0] m_q;
    logic          m_qv;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_clr_left = DEPTH;
        m_q        = '0;
        m_qv       = 1'b0;
    endfunction

    // One clock edge of the specified behaviour
    function automatic void model_edge(input logic en, input logic we,
                                       input logic [AW-1:0] a, input logic [DW-1:0] d,
                                       input logic clr);
        m_qv = 1'b0;
        if (m_clr_left > 0) begin
            m_mem[DEPTH - m_clr_left] = '0;
            m_clr_left--;
            if (clr) m_clr_left = DEPTH;
        end else if (clr) begin
            m_clr_left = DEPTH;
        end else if (en && we) begin
            m_mem[a] = d;
        end else if (en) begin
            m_q  = m_mem[a];
            m_qv = 1'b1;
        end
    endfunction

    // Called at posedge+1: apply inputs, take one edge, compare outputs at posedge+1
    task automatic step(input logic en, input logic we, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input logic clr);
        bus.en  = en;
        bus.we  = we;
        bus.a   = a;
        bus.d   = d;
        bus.clr = clr;
        @(posedge clk_i);
        model_edge(en, we, a, d, clr);
        #1;
        bus.en  = 1'b0;
        bus.clr = 1'b0;
        check("q",   32'(bus.q),   32'(m_q));
        check("qv",  32'(bus.qv),  32'(m_qv));
        check("rdy", 32'(bus.rdy), 32'(m_clr_left == 0));
    endtask

    // Asynchronous reset from posedge+1: outputs must clear before any edge
    task automatic do_reset();
        rst_i = 1'b1;
        #1;
        check("rst_q",   32'(bus.q),   32'h0);
        check("rst_qv",  32'(bus.qv),  32'h0);
        check("rst_rdy", 32'(bus.rdy), 32'h0);
        model_reset();
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
    endtask

    task automatic wait_ready();
        for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b0, '0, '0, 1'b0);
    endtask

    initial begin
        bus.en  = 1'b0;
        bus.we  = 1'b0;
        bus.a   = '0;
        bus.d   = '0;
        bus.clr = 1'b0;
        for (int i = 0; i < DEPTH; i++) m_mem[i] = 'x;
        model_reset();

        // Power-on reset
        repeat (2) @(posedge clk_i);
        #1;
        check("por_q",   32'(bus.q),   32'h0);
        check("por_qv",  32'(bus.qv),  32'h0);
        check("por_rdy", 32'(bus.rdy), 32'h0);
        rst_i = 1'b0;

        // 1: rdy low for exactly DEPTH cycles, then every word reads INIT_VAL
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b0, 1'b0, '0, '0, 1'b0);
            check("t1_rdy", 32'(bus.rdy), 32'(i == DEPTH - 1));
        end
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b1, 1'b0, AW'(i), '0, 1'b0);
            check("t1_q", 32'(bus.q), 32'h0);
            check("t1_qv", 32'(bus.qv), 32'h1);
        end

        // 2: writes then back-to-back reads
        step(1'b1, 1'b1, 2'd1, 4'hA, 1'b0);
        check("t2_wr_qv", 32'(bus.qv), 32'h0);
        step(1'b1, 1'b1, 2'd2, 4'h5, 1'b0);
        step(1'b1, 1'b0, 2'd2, '0, 1'b0);
        check("t2_q2", 32'(bus.q), 32'h5);
        check("t2_qv2", 32'(bus.qv), 32'h1);
        step(1'b1, 1'b0, 2'd1, '0, 1'b0);
        check("t2_q1", 32'(bus.q), 32'hA);
        check("t2_qv1", 32'(bus.qv), 32'h1);
        step(1'b0, 1'b0, '0, '0, 1'b0);
        check("t2_hold_q", 32'(bus.q), 32'hA);

        // 3: write during clear is dropped
        step(1'b0, 1'b0, '0, '0, 1'b1);
        step(1'b1, 1'b1, 2'd3, 4'hF, 1'b0);
        wait_ready();
        step(1'b1, 1'b0, 2'd3, '0, 1'b0);
        check("t3_q", 32'(bus.q), 32'h0);

        // 4: clr wins over a simultaneous write
        step(1'b1, 1'b1, 2'd0, 4'h7, 1'b1);
        check("t4_rdy_fall", 32'(bus.rdy), 32'h0);
        wait_ready();
        step(1'b1, 1'b0, 2'd0, '0, 1'b0);
        check("t4_q", 32'(bus.q), 32'h0);

        // Read immediately after a write to the same address
        step(1'b1, 1'b1, 2'd3, 4'h9, 1'b0);
        step(1'b1, 1'b0, 2'd3, '0, 1'b0);
        check("raw_q", 32'(bus.q), 32'h9);

        // 5: reset during a read, then clear re-runs
        step(1'b1, 1'b0, 2'd3, '0, 1'b0);
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b0, 1'b0, '0, '0, 1'b0);
            check("t5_rdy", 32'(bus.rdy), 32'(i == DEPTH - 1));
        end
        step(1'b1, 1'b0, 2'd3, '0, 1'b0);
        check("t5_q", 32'(bus.q), 32'h0);

`ifdef RAM_PARITY_EN
        // 6: corrupted parity bit flags perr, clean word does not
        step(1'b1, 1'b1, 2'd1, 4'h6, 1'b0);
        @(negedge clk_i);
        dut.mem_q[1][DW] = ~dut.mem_q[1][DW];
        @(posedge clk_i);
        #1;
        step(1'b1, 1'b0, 2'd1, '0, 1'b0);
        check("t6_perr1", 32'(bus.perr), 32'h1);
        check("t6_q1", 32'(bus.q), 32'h6);
        step(1'b1, 1'b0, 2'd2, '0, 1'b0);
        check("t6_perr0", 32'(bus.perr), 32'h0);
        step(1'b1, 1'b1, 2'd1, 4'h6, 1'b0);
`endif

        // Random traffic with occasional clear pulses and resets
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 149) == 0) begin
                do_reset();
            end else begin
                step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                     AW'($urandom_range(0, DEPTH - 1)), DW'($urandom_range(0, 15)),
                     1'($urandom_range(0, 29) == 0));
            end
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    // Hard bound in case the clock or bench stalls
    initial begin
        #200000;
        $display("FAIL timeout checks=%0d errors=%0d", n_checks, n_errors);
        $fatal(1, "timeout");
    end

endmodule
